// File: rtl/em_pio_ctrl_if.sv
// em_pio_ctrl_if: Avalon-MM slave bus and pin bundle for em_pio_ctrl
interface em_pio_ctrl_if #(parameter int WIDTH = 10);
    logic [2:0]       address;
    logic             chipselect;
    logic             read_n;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic [WIDTH-1:0] out_port;
    logic [WIDTH-1:0] oe;
    logic             irq;
    modport master (
        output address, chipselect, read_n, write_n, writedata, in_port,
        input  readdata, out_port, oe, irq
    );
    modport slave (
        input  address, chipselect, read_n, write_n, writedata, in_port,
        output readdata, out_port, oe, irq
    );
endinterface

// File: rtl/em_pio_ctrl.sv
// em_pio_ctrl: Avalon-MM GPIO with per-bit direction, set/clear, synchronised inputs, edge capture and irq
module em_pio_ctrl #(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '1,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input logic          clk,
    input logic          reset,
    em_pio_ctrl_if.slave bus
);
    localparam logic [2:0] ARM = 3'(SYNC_STAGES + 1);
    logic [WIDTH-1:0]                  r_data, r_dir, r_mask, r_cap, r_prev;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [2:0]                        r_arm;
    logic [31:0]                       r_readdata;
    logic                              w_wr, w_rd, w_unused;
    logic [WIDTH-1:0]                  w_wd, w_sync, w_edge, w_set, w_clr, w_rdval;
    assign w_wr     = bus.chipselect & ~bus.write_n;
    assign w_rd     = bus.chipselect & ~bus.read_n;
    assign w_wd     = bus.writedata[WIDTH-1:0];
    assign w_unused = ^bus.writedata;
    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_edge   = EDGE_TYPE == 0 ? w_sync & ~r_prev :
                      EDGE_TYPE == 1 ? ~w_sync & r_prev : w_sync ^ r_prev;
    // edges are ignored until the synchroniser has flushed the reset zeros
    assign w_set    = r_arm == ARM ? w_edge & ~r_dir : '0;
    assign w_clr    = w_wr && bus.address == 3'd3 ? w_wd : '0;
    always_comb begin
        w_rdval = bus.address == 3'd0 ? (r_data & r_dir) | (w_sync & ~r_dir) :
                  bus.address == 3'd1 ? r_dir :
                  bus.address == 3'd2 ? r_mask :
                  bus.address == 3'd3 ? r_cap : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= RESET_VALUE;
            r_dir      <= DIR_RESET;
            r_mask     <= '0;
            r_cap      <= '0;
            r_prev     <= '0;
            r_sync     <= '0;
            r_arm      <= '0;
            r_readdata <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.in_port};
            r_prev <= w_sync;
            if (r_arm != ARM)
                r_arm <= r_arm + 3'd1;
            if (w_rd)
                r_readdata <= 32'(w_rdval);
            if (w_wr)
                r_data <= bus.address == 3'd0 ? w_wd :
                          bus.address == 3'd4 ? r_data | w_wd :
                          bus.address == 3'd5 ? r_data & ~w_wd : r_data;
            if (w_wr && bus.address == 3'd1)
                r_dir <= w_wd;
            if (w_wr && bus.address == 3'd2)
                r_mask <= w_wd;
            r_cap <= (r_cap & ~w_clr) | w_set;
        end
    end
    assign bus.readdata = r_readdata;
    assign bus.out_port = r_data;
    assign bus.oe       = r_dir;
    assign bus.irq      = |(r_cap & r_mask);
endmodule

// File: tb/tb_em_pio_ctrl.sv
// tb_em_pio_ctrl: directed test-plan steps plus random bus/pin traffic against a cycle-level reference model
module tb_em_pio_ctrl;
    localparam int              W  = 10;
    localparam int              S  = 2;
    localparam logic [W-1:0]    RV = 10'h155;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0] pins = '0;
    always #5 clk = ~clk;
    em_pio_ctrl_if #(.WIDTH(W)) bus();
    em_pio_ctrl #(
        .WIDTH(W), .RESET_VALUE(RV), .DIR_RESET(10'h3FF), .EDGE_TYPE(0), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;
    // model: sync_in is simply the pin value S samples ago; m_pins[0] is the newest sample
    logic [W-1:0] m_data, m_dir, m_mask, m_cap;
    logic [31:0]  m_rd;
    logic [W-1:0] m_pins[$];
    int           m_cyc;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [W-1:0] sy;
        sy = m_pins[S-1];
        return a == 3'd0 ? 32'((m_data & m_dir) | (sy & ~m_dir)) :
               a == 3'd1 ? 32'(m_dir) :
               a == 3'd2 ? 32'(m_mask) :
               a == 3'd3 ? 32'(m_cap) : 32'd0;
    endfunction
    task automatic step(input logic r, input logic [2:0] a, input logic cs, input logic rn,
                        input logic wn, input logic [31:0] wd);
        logic [W-1:0] sy, pv, wv, setb;
        reset          = r;
        bus.address    = a;
        bus.chipselect = cs;
        bus.read_n     = rn;
        bus.write_n    = wn;
        bus.writedata  = wd;
        bus.in_port    = pins;
        @(posedge clk);
        if (r) begin
            m_data = RV; m_dir = '1; m_mask = '0; m_cap = '0; m_rd = '0; m_cyc = 0;
            m_pins.delete();
            repeat (S + 1) m_pins.push_back('0);
        end else begin
            sy   = m_pins[S-1];
            pv   = m_pins[S];
            wv   = wd[W-1:0];
            setb = m_cyc >= S + 1 ? sy & ~pv & ~m_dir : '0;
            if (cs && !rn) m_rd = m_read(a);
            if (cs && !wn) begin
                if (a == 3'd0) m_data = wv;
                if (a == 3'd1) m_dir = wv;
                if (a == 3'd2) m_mask = wv;
                if (a == 3'd3) m_cap = m_cap & ~wv;
                if (a == 3'd4) m_data = m_data | wv;
                if (a == 3'd5) m_data = m_data & ~wv;
            end
            m_cap = m_cap | setb;
            m_pins.push_front(pins);
            void'(m_pins.pop_back());
            m_cyc++;
        end
        @(negedge clk);
        chk("m_out_port", 32'(bus.out_port), 32'(m_data));
        chk("m_oe", 32'(bus.oe), 32'(m_dir));
        chk("m_irq", 32'(bus.irq), 32'(|(m_cap & m_mask)));
        chk("m_readdata", bus.readdata, m_rd);
    endtask
    task automatic rst();              step(1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 32'd0); endtask
    task automatic idle();             step(1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 32'd0); endtask
    task automatic rd(input logic [2:0] a);
        step(1'b0, a, 1'b1, 1'b0, 1'b1, 32'd0);
    endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step(1'b0, a, 1'b1, 1'b1, 1'b0, d);
    endtask
    initial begin
        rst(); rst();
        chk("rst_out_port", 32'(bus.out_port), 32'h155);
        chk("rst_oe", 32'(bus.oe), 32'h3FF);
        chk("rst_irq", 32'(bus.irq), 32'd0);
        rd(3'd0);
        chk("rst_read_data", bus.readdata, 32'h155);
        wr(3'd4, 32'h00A);
        chk("outset", 32'(bus.out_port), 32'h15F);
        wr(3'd5, 32'h101);
        chk("outclear", 32'(bus.out_port), 32'h05E);
        rd(3'd4);
        chk("read_outset", bus.readdata, 32'd0);
        wr(3'd1, 32'h00F);
        wr(3'd0, 32'h005);
        pins = 10'h2A0;
        repeat (3) idle();
        rd(3'd0);
        chk("read_mixed", bus.readdata, 32'h2A5);
        wr(3'd1, 32'h000);
        pins = '0;
        repeat (4) idle();
        wr(3'd3, 32'h3FF);
        wr(3'd2, 32'h001);
        chk("irq_idle", 32'(bus.irq), 32'd0);
        pins = 10'h001;
        idle(); idle();
        chk("irq_two_edges", 32'(bus.irq), 32'd0);
        idle();
        chk("irq_three_edges", 32'(bus.irq), 32'd1);
        rd(3'd3);
        chk("capture_bit0", bus.readdata, 32'h001);
        wr(3'd3, 32'h001);
        chk("irq_cleared", 32'(bus.irq), 32'd0);
        rst();
        wr(3'd1, 32'h000);
        wr(3'd2, 32'h001);
        repeat (5) idle();
        chk("arm_irq", 32'(bus.irq), 32'd0);
        rd(3'd3);
        chk("arm_capture", bus.readdata, 32'd0);
        pins = '0;
        repeat (3) idle();
        pins = 10'h001;
        idle(); idle();
        wr(3'd3, 32'h001);
        chk("set_wins_irq", 32'(bus.irq), 32'd1);
        rd(3'd3);
        chk("set_wins_capture", bus.readdata, 32'h001);
        wr(3'd2, 32'h3FF);
        pins = '0;
        repeat (3) idle();
        pins = 10'h3FF;
        repeat (3) idle();
        chk("all_irq", 32'(bus.irq), 32'd1);
        rd(3'd3);
        chk("all_capture", bus.readdata, 32'h3FF);
        rst();
        chk("rst_mid_irq", 32'(bus.irq), 32'd0);
        rd(3'd2);
        chk("rst_mid_mask", bus.readdata, 32'd0);
        rd(3'd3);
        chk("rst_mid_capture", bus.readdata, 32'd0);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) pins = W'($urandom);
            step($urandom_range(0, 99) == 0, 3'($urandom_range(0, 7)), 1'($urandom),
                 1'($urandom), 1'($urandom), $urandom);
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
